// File: rtl/k12a_spi_slave.sv
// k12a_spi_slave: SPI mode-0 responder, pins oversampled in the cpu_clock domain,
// with single-entry transmit/receive holding registers and ready/valid handshakes.
module k12a_spi_slave #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input  logic       cpu_clock,
   input  logic       reset_n,
   input  logic       spi_sck,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       overrun,
   output logic       busy
);
   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t          state, state_nxt;
   logic [NS-1:0]   sck_sync, mosi_sync, cs_sync;
   logic            sck_prev, cs_prev;
   logic            sck_s, mosi_s, cs_s;
   logic            sck_rise, sck_fall, cs_rise, cs_fall;
   logic            start, stop, rise_ev, fall_ev, byte_done, reload, take, tx_accept;
   logic [2:0]      bit_cnt;
   logic [7:0]      rx_shift, tx_shift, tx_buf, rx_byte;
   logic            tx_full;

   // chip select chain resets to the deasserted level so reset release never looks like a select
   always_ff @(posedge cpu_clock or negedge reset_n)
      if (!reset_n) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         sck_prev  <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[NS-2:0], spi_sck};
         mosi_sync <= {mosi_sync[NS-2:0], spi_mosi};
         cs_sync   <= {cs_sync[NS-2:0], spi_cs_n};
         sck_prev  <= sck_s;
         cs_prev   <= cs_s;
      end

   assign sck_s    = sck_sync[NS-1];
   assign mosi_s   = mosi_sync[NS-1];
   assign cs_s     = cs_sync[NS-1];
   assign sck_rise = sck_s & ~sck_prev;
   assign sck_fall = ~sck_s & sck_prev;
   assign cs_fall  = ~cs_s & cs_prev;
   assign cs_rise  = cs_s & ~cs_prev;

   always_ff @(posedge cpu_clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      stop      = 1'b0;
      rise_ev   = 1'b0;
      fall_ev   = 1'b0;
      if (state == IDLE) begin
         start     = cs_fall;
         state_nxt = cs_fall ? ACTIVE : IDLE;
      end else begin
         stop      = cs_rise;
         rise_ev   = sck_rise & ~cs_rise;
         fall_ev   = sck_fall & ~cs_rise;
         state_nxt = cs_rise ? IDLE : ACTIVE;
      end
   end

   assign byte_done = rise_ev & (bit_cnt == 3'd7);
   assign reload    = start | (fall_ev & (bit_cnt == 3'd0));
   assign take      = reload & tx_full;
   // a load arriving as the buffer drains is accepted behind the outgoing byte
   assign tx_accept = tx_load & (~tx_full | take);
   assign rx_byte   = {rx_shift[6:0], mosi_s};

   always_ff @(posedge cpu_clock or negedge reset_n)
      if (!reset_n) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         tx_buf   <= '0;
         tx_full  <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         bit_cnt  <= (start | stop) ? 3'd0 : rise_ev ? bit_cnt + 3'd1 : bit_cnt;
         rx_shift <= (start | stop) ? 8'h00 : rise_ev ? rx_byte : rx_shift;
         tx_shift <= reload ? (tx_full ? tx_buf : IDLE_BYTE) : fall_ev ? {tx_shift[6:0], 1'b0} : tx_shift;
         tx_buf   <= tx_accept ? tx_data : tx_buf;
         tx_full  <= tx_accept | (tx_full & ~take);
         rx_data  <= byte_done ? rx_byte : rx_data;
         rx_valid <= byte_done | (rx_valid & ~rx_ack);
         overrun  <= ~rx_ack & (overrun | (byte_done & rx_valid));
      end

   assign spi_miso = (state == ACTIVE) & tx_shift[7];
   assign busy     = (state == ACTIVE);
   assign tx_ready = ~tx_full;
endmodule

// File: doc/k12a_spi_slave.md
# k12a_spi_slave

SPI mode-0 responder peripheral: the device-side end of the SPI links that the k12a I/O block drives as master. It lets an external SPI master (or a second k12a wired back-to-back) exchange bytes with the CPU. Pin inputs are oversampled in the CPU clock domain, and bytes pass through single-entry transmit and receive holding registers with ready/valid handshakes. The block sits beside `k12a_io` and is reached through its I/O port decode.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on each of `spi_sck`, `spi_mosi`, `spi_cs_n` (minimum 2).
- `IDLE_BYTE`, 8'hFF: byte shifted out when no transmit byte is queued.

Ports:
- `cpu_clock` input 1: the only clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `spi_sck` input 1: serial clock from the master, asynchronous.
- `spi_cs_n` input 1: active-low chip select from the master, asynchronous.
- `spi_mosi` input 1: master-out data, asynchronous.
- `spi_miso` output 1: slave-out data.
- `tx_data` input 8: byte to transmit.
- `tx_load` input 1: write `tx_data` into the transmit buffer.
- `tx_ready` output 1: transmit buffer empty.
- `rx_data` output 8: last received byte.
- `rx_valid` output 1: `rx_data` holds an unread byte.
- `rx_ack` input 1: consume `rx_data`.
- `overrun` output 1: a byte completed while `rx_valid` was still set.
- `busy` output 1: chip select is asserted (synchronized).

## Operation
- Reset values: `spi_miso`=0, `tx_ready`=1, `rx_data`=8'h00, `rx_valid`=0, `overrun`=0, `busy`=0. The shift registers, bit counter and edge-detect history all clear.
- Edge detection: each synchronized input is compared with its value one cycle earlier.
  - `sck_rise`/`sck_fall` mark SCK edges.
  - `cs_fall`/`cs_rise` mark chip-select edges.
- States:
  - IDLE → ACTIVE on `cs_fall`.
  - ACTIVE → IDLE on `cs_rise`.
  - SCK edges are ignored in IDLE.
- On entry to ACTIVE (`cs_fall` cycle):
  - The bit counter clears to 0.
  - The tx shift register loads from the transmit buffer if it is full, then the buffer empties. Otherwise it loads `IDLE_BYTE`.
- `sck_rise` in ACTIVE:
  - `spi_mosi` (synchronized) shifts into the rx shift register LSB. Bytes are MSB first.
  - The 3-bit counter increments.
  - When the counter wraps 7→0, the assembled byte goes to `rx_data` and `rx_valid` is set.
  - If `rx_valid` was already 1 and `rx_ack` is not high in the same cycle, `overrun` is set and `rx_data` is overwritten with the newest byte.
- `sck_fall` in ACTIVE:
  - If the counter is 0 (a byte just completed), the tx shift register reloads from the buffer or `IDLE_BYTE` by the rule above.
  - Otherwise it shifts left by one.
- `spi_miso` = tx shift register bit 7 while ACTIVE, else 0.
- `rx_ack` clears `rx_valid` and `overrun`. If a byte completes in the same cycle, `rx_valid` stays 1 and `overrun` ends 0.
- `tx_load` writes the buffer only when `tx_ready`=1; it is ignored when the buffer is full. If `tx_load` coincides with a shift-register load that empties the buffer:
  - The old byte goes to the shift register.
  - The new byte is accepted into the buffer.
  - `tx_ready` stays 0.
- Chip select deasserted mid-byte: the partial rx byte is discarded with no `rx_valid`. The partially sent tx byte is lost and not re-queued. The counter clears.
- `reset_n` low mid-transfer: immediate return to reset values. A queued tx byte is discarded.

## Timing
- Pin-to-event latency is `SYNC_STAGES`+1 `cpu_clock` edges. The state update occurs on that edge.
- Timing requirements on the master:
  - SCK high time and low time are each ≥ `SYNC_STAGES`+2 `cpu_clock` periods.
  - CS setup to the first SCK rise is ≥ `SYNC_STAGES`+2 periods.
- With the defaults, `rx_valid` rises 3 `cpu_clock` edges after the 8th SCK rising edge at the pin.
- `spi_miso` changes at most `SYNC_STAGES`+1 cycles after an SCK falling edge. It is therefore stable before the next SCK rise given the high/low requirement.
- `tx_ready` rises on the cycle of the load that empties the buffer. It falls one cycle after an accepted `tx_load`.

## Test plan
- Reset, then drive MOSI byte 8'hA5 with `tx_load` of 8'h3C beforehand → `rx_data`=8'hA5 with `rx_valid`=1; master samples 8'h3C on MISO; `tx_ready` returns to 1 at `cs_fall`.
- Two back-to-back bytes 8'h01 then 8'h02 without `rx_ack` → `rx_data`=8'h02, `overrun`=1. After `rx_ack`, both `rx_valid` and `overrun` are 0.
- Transfer with no byte queued → master receives 8'hFF. Then queue 8'h55 mid-byte → the next byte sent is 8'h55.
- CS deasserted after 5 SCK rises → no `rx_valid`. The next full byte 8'hC3 is received correctly, aligned from bit 7.
- `tx_load` pulsed while `tx_ready`=0 with 8'h99 → ignored; the originally queued 8'h42 is transmitted.
- Assert `reset_n` low after 4 bits of a byte → all outputs at reset values; the following transfer of 8'h81 completes normally.
